// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / exception controller for a 5-stage pipeline.
//
// Chooses, every cycle, between holding part of the pipeline (stall), clearing
// the pipeline registers and redirecting fetch (flush/new_pc), or letting
// everything advance. After a flush, a one-cycle GUARD state lets the
// redirected fetch settle before another exception or stall request is
// accepted. It also keeps a free-running stall-cycle counter and a sticky
// watchdog flag for stall runs that last too long.
//
// Parameters
//   EXC_VECTOR     exception handler entry address
//   TIMEOUT        consecutive-stall-cycle count that trips the watchdog
//
// Ports
//   clk            single clock, rising-edge active
//   rst            synchronous active-high reset
//   stallreq_id    ID-stage stall request (load-use hazard)
//   stallreq_ex    EX-stage stall request (multi-cycle operation)
//   stallreq_mem   MEM-stage stall request (data bus wait)
//   excepttype_i   exception code from MEM, 0 = none, 32'h0000000e = eret
//   cp0_epc_i      current CP0 EPC, return address for eret
//   stall[5:0]     per-stage hold, bit0 PC .. bit5 WB, 1 = hold
//   flush          clear pipeline registers and redirect fetch
//   new_pc         redirect address, zero whenever flush is low
//   stall_timeout  sticky watchdog flag, cleared only by reset
//   stall_cnt      total stall cycles, wraps at 2^32
//
// stall, flush and new_pc are combinational from state and inputs so the
// hazard response takes effect in the cycle the request is raised.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [15:0] TIMEOUT    = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } state_e;

  localparam logic [31:0] ERET_CODE = 32'h0000000e;

  // Hold patterns: a stage's request freezes that stage and everything
  // upstream of it, while downstream stages keep draining.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;

  state_e      state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        timeout_q, timeout_d;

  logic        exc_pending_s;
  logic        stall_active_s;

  assign exc_pending_s  = (excepttype_i != 32'h00000000);
  assign stall_active_s = (stall != STALL_NONE);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= 32'h00000000;
      run_cnt_q   <= 16'h0000;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic: a flush from IDLE always buys exactly one GUARD cycle.
  // A memory stall outranks the exception, so the FSM stays in IDLE and the
  // exception is taken once the bus wait ends.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stallreq_mem && exc_pending_s) begin
            state_d = ST_GUARD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GUARD: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: priority mem > exception > ex > id in IDLE; GUARD and reset
  // force everything quiet.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h00000000;
    if (rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = 32'h00000000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stallreq_mem) begin
            stall = STALL_MEM;
          end else if (exc_pending_s) begin
            flush = 1'b1;
            if (excepttype_i == ERET_CODE) begin
              new_pc = cp0_epc_i;
            end else begin
              new_pc = EXC_VECTOR;
            end
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end else begin
            stall = STALL_NONE;
          end
        end
        ST_GUARD: begin
          stall  = STALL_NONE;
          flush  = 1'b0;
          new_pc = 32'h00000000;
        end
        default: begin
          stall  = STALL_NONE;
          flush  = 1'b0;
          new_pc = 32'h00000000;
        end
      endcase
    end
  end

  // Performance counter, consecutive-stall run length and sticky watchdog.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_cnt_d   = run_cnt_q;
    timeout_d   = timeout_q;
    if (stall_active_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
      if (run_cnt_q == 16'hFFFF) begin
        run_cnt_d = run_cnt_q;
      end else begin
        run_cnt_d = run_cnt_q + 16'd1;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
      run_cnt_d   = 16'h0000;
    end
    // The flag latches on the edge where the run length lands on TIMEOUT.
    if (run_cnt_d == TIMEOUT) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = timeout_q;

  pipe_ctrl_chk u_chk (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout)
  );

endmodule

// -----------------------------------------------------------------------------
// pipe_ctrl_chk -- structural invariants of pipe_ctrl outputs.
//
// Ports
//   clk, rst       clock and synchronous reset of the checked block
//   stall, flush   hold vector and flush strobe
//   new_pc         redirect address
//   stall_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
module pipe_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic [5:0]  stall,
  input logic        flush,
  input logic [31:0] new_pc,
  input logic        stall_timeout
);

  // A flush never coincides with a hold.
  a_flush_no_stall : assert property (@(posedge clk) disable iff (rst)
    flush |-> (stall == 6'b000000));

  // new_pc carries a value only alongside flush.
  a_pc_zero_idle : assert property (@(posedge clk) disable iff (rst)
    !flush |-> (new_pc == 32'h00000000));

  // Only the three defined hold shapes may appear.
  a_stall_legal : assert property (@(posedge clk) disable iff (rst)
    (stall == 6'b000000) || (stall == 6'b000111) ||
    (stall == 6'b001111) || (stall == 6'b011111));

  // Watchdog flag stays set until a reset edge.
  a_timeout_sticky : assert property (@(posedge clk)
    (stall_timeout && !rst) |=> stall_timeout);

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl.
// A driver applies one directed vector per cycle just after the rising edge
// and queues the hand-computed response; a monitor pops one entry per falling
// edge and compares stall, flush, new_pc, stall_cnt and stall_timeout.
// stall_cnt/stall_timeout expectations are the register values after all
// earlier edges. The DUT runs with TIMEOUT = 4 for a short watchdog scenario.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;
  localparam logic [31:0] VEC = 32'h00000020;
  localparam logic [31:0] Z32 = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR (32'h00000020),
    .TIMEOUT    (16'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(input string name, input logic r, input logic id,
                      input logic ex, input logic mem,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] es, input logic ef,
                      input logic [31:0] ep, input logic [31:0] ec,
                      input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    e.name  = name;
    e.stall = es;
    e.flush = ef;
    e.pc    = ep;
    e.cnt   = ec;
    e.to    = eto;
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "stall",   {26'd0, stall},         {26'd0, e.stall});
      chk(e.name, "flush",   {31'd0, flush},         {31'd0, e.flush});
      chk(e.name, "new_pc",  new_pc,                 e.pc);
      chk(e.name, "cnt",     stall_cnt,              e.cnt);
      chk(e.name, "timeout", {31'd0, stall_timeout}, {31'd0, e.to});
    end
  end

  initial begin
    rst          = 1'b1;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excepttype_i = Z32;
    cp0_epc_i    = Z32;
    repeat (2) @(posedge clk);

    //   name        rst   id    ex    mem   exc           epc           stall flush pc  cnt  to
    step("rst_quiet",1'b1, 1'b0, 1'b0, 1'b1, 32'h00000008, Z32,          S0, 1'b0, Z32, 32'd0,  1'b0);
    step("idle",     1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd0,  1'b0);
    // Priority: each request alone for one cycle.
    step("pri_id",   1'b0, 1'b1, 1'b0, 1'b0, Z32,          Z32,          SI, 1'b0, Z32, 32'd0,  1'b0);
    step("pri_ex",   1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd1,  1'b0);
    step("pri_mem",  1'b0, 1'b0, 1'b0, 1'b1, Z32,          Z32,          SM, 1'b0, Z32, 32'd2,  1'b0);
    step("cnt3",     1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd3,  1'b0);
    // Overlapping requests resolve to the highest priority.
    step("ex_ov_id", 1'b0, 1'b1, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd3,  1'b0);
    step("mem_ov",   1'b0, 1'b1, 1'b1, 1'b1, Z32,          Z32,          SM, 1'b0, Z32, 32'd4,  1'b0);
    step("idle2",    1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd5,  1'b0);
    // Exception, then GUARD ignores a stall request.
    step("exc8",     1'b0, 1'b0, 1'b0, 1'b0, 32'h00000008, Z32,          S0, 1'b1, VEC, 32'd5,  1'b0);
    step("guard_ex", 1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd5,  1'b0);
    // eret redirects to EPC.
    step("eret",     1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000e, 32'h00001234, S0, 1'b1, 32'h00001234, 32'd5, 1'b0);
    step("guard2",   1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd5,  1'b0);
    // Deferral behind a memory stall, then guard pattern 1,0,1.
    step("defer1",   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000c, Z32,          SM, 1'b0, Z32, 32'd5,  1'b0);
    step("defer2",   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000c, Z32,          SM, 1'b0, Z32, 32'd6,  1'b0);
    step("defer3",   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000c, Z32,          SM, 1'b0, Z32, 32'd7,  1'b0);
    step("defer_fl", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000c, Z32,          S0, 1'b1, VEC, 32'd8,  1'b0);
    step("guard_c",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000c, Z32,          S0, 1'b0, Z32, 32'd8,  1'b0);
    step("refl_c",   1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000c, Z32,          S0, 1'b1, VEC, 32'd8,  1'b0);
    // Memory stall held across GUARD is serviced afterwards.
    step("guard_m",  1'b0, 1'b0, 1'b0, 1'b1, Z32,          Z32,          S0, 1'b0, Z32, 32'd8,  1'b0);
    step("post_m",   1'b0, 1'b0, 1'b0, 1'b1, Z32,          Z32,          SM, 1'b0, Z32, 32'd8,  1'b0);
    step("idle3",    1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd9,  1'b0);
    // Watchdog: run of 3, gap, run of 4 trips it.
    step("wd_a1",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd9,  1'b0);
    step("wd_a2",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd10, 1'b0);
    step("wd_a3",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd11, 1'b0);
    step("wd_gap",   1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd12, 1'b0);
    step("wd_b1",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd12, 1'b0);
    step("wd_b2",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd13, 1'b0);
    step("wd_b3",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd14, 1'b0);
    step("wd_b4",    1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd15, 1'b0);
    step("wd_set",   1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd16, 1'b1);
    step("wd_hold1", 1'b0, 1'b0, 1'b1, 1'b0, Z32,          Z32,          SE, 1'b0, Z32, 32'd16, 1'b1);
    step("wd_hold2", 1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd17, 1'b1);
    // Reset while in GUARD drops the pending exception and clears counters.
    step("pre_rst",  1'b0, 1'b0, 1'b0, 1'b0, 32'h00000008, Z32,          S0, 1'b1, VEC, 32'd17, 1'b1);
    step("rst_grd",  1'b1, 1'b0, 1'b0, 1'b0, 32'h00000008, Z32,          S0, 1'b0, Z32, 32'd17, 1'b1);
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd0,  1'b0);
    // Back in IDLE: exception outranks ex/id requests.
    step("exc_ov",   1'b0, 1'b1, 1'b1, 1'b0, 32'h00000008, Z32,          S0, 1'b1, VEC, 32'd0,  1'b0);
    step("final",    1'b0, 1'b0, 1'b0, 1'b0, Z32,          Z32,          S0, 1'b0, Z32, 32'd0,  1'b0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h00000020, is the exception handler entry address.
REQ-002 Parameter TIMEOUT, default 16'd1023, is the consecutive-stall-cycle watchdog threshold.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset (RstEnable = 1).
REQ-005 stallreq_id  input  1  stall request from the ID stage (load-use hazard).
REQ-006 stallreq_ex  input  1  stall request from the EX stage (multi-cycle op).
REQ-007 stallreq_mem  input  1  stall request from the MEM stage (data bus wait).
REQ-008 excepttype_i  input  32  exception code from MEM; 0 = none, 32'h0000000e = eret.
REQ-009 cp0_epc_i  input  32  current CP0 EPC value.
REQ-010 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-011 flush  output  1  pipeline-register clear, 1 = WriteEnable.
REQ-012 new_pc  output  32  redirect address, valid only while flush = 1.
REQ-013 stall_timeout  output  1  sticky watchdog flag.
REQ-014 stall_cnt  output  32  total stall cycles, performance counter.

Function
REQ-015 FSM states: IDLE and GUARD; reset state IDLE.
REQ-016 IDLE priority, highest first: stallreq_mem, exception (excepttype_i != 0), stallreq_ex, stallreq_id, none.
REQ-017 stallreq_mem = 1 -> stall = 6'b011111, flush = 0; any pending exception is deferred, not dropped.
REQ-018 stallreq_mem = 0 and excepttype_i != 0 -> flush = 1, stall = 6'b000000 in the same cycle (combinational); next state GUARD.
REQ-019 During flush, new_pc = cp0_epc_i if excepttype_i == 32'h0000000e, else new_pc = EXC_VECTOR.
REQ-020 flush = 0 -> new_pc = 32'h00000000.
REQ-021 No exception and stallreq_ex = 1 -> stall = 6'b001111.
REQ-022 No exception, stallreq_ex = 0 and stallreq_id = 1 -> stall = 6'b000111.
REQ-023 No requests -> stall = 6'b000000, flush = 0.
REQ-024 GUARD lasts exactly one cycle:
  - flush = 0, stall = 6'b000000
  - excepttype_i and all stall requests ignored
  - next state IDLE unconditionally.
REQ-025 Stall requests and exceptions held across GUARD are serviced in the following IDLE cycle per REQ-016.
REQ-026 stall_cnt increments by 1 on each clock edge where stall != 0, and wraps from 32'hFFFFFFFF to 0.
REQ-027 An internal 16-bit run counter behaves as follows:
  - increments, saturating at 16'hFFFF, on each edge where stall != 0
  - clears to 0 on each edge where stall == 0.
REQ-028 stall_timeout is set on the edge where the run counter reaches TIMEOUT, and stays 1 until reset.
REQ-029 stall, flush and new_pc are functions of the current state and current inputs only; no input-to-output register delay.

Reset
REQ-030 With rst = 1 at a rising edge: state -> IDLE, stall_cnt -> 0, run counter -> 0, stall_timeout -> 0.
REQ-031 While rst = 1: stall = 6'b000000, flush = 0, new_pc = 32'h00000000, regardless of other inputs.
REQ-032 Reset asserted in GUARD returns the FSM to IDLE; a deferred exception is not retained across reset.

Verification
REQ-033 Priority check: stallreq_id = 1, then stallreq_ex = 1, then stallreq_mem = 1, each alone one cycle -> stall = 000111, 001111, 011111; stall_cnt = 3.
REQ-034 Exception and eret:
  - excepttype_i = 32'h00000008, no stalls -> flush = 1, new_pc = 32'h00000020, stall = 0; next cycle GUARD with flush = 0.
  - excepttype_i = 32'h0000000e, cp0_epc_i = 32'h00001234 -> new_pc = 32'h00001234.
REQ-035 Deferral: excepttype_i = 32'h0000000c with stallreq_mem = 1 for 3 cycles -> stall = 011111, flush = 0 for those cycles; flush = 1 in the cycle stallreq_mem drops.
REQ-036 Guard: excepttype_i held nonzero 3 cycles -> flush pattern 1, 0, 1 (IDLE, GUARD, IDLE).
REQ-037 Watchdog, TIMEOUT = 4:
  - stallreq_ex high 3 cycles, low 1 cycle, high 4 cycles -> stall_timeout rises only after the 4th cycle of the second run
  - stall_timeout stays 1 afterwards until rst clears it.
